// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking in front of one UART transmitter.
// A one-entry holding register drives the UART DataIn handshake.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic [7:0]       uart_data_in,
  output logic             uart_data_in_valid,
  input  logic             uart_data_in_ready,
  output logic [1:0]       grant,
  output logic             timeout_evt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             vld_q, vld_d;
  logic             tevt_q, tevt_d;

  logic       load_en;
  logic       sel;
  logic       sel_vld;
  logic       acc0;
  logic       acc1;
  logic       acc;
  logic       acc_last;
  logic [7:0] acc_data;
  logic       own_vld;

  always_comb begin
    load_en = !vld_q || uart_data_in_ready;
    sel     = ptr_q;
    sel_vld = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          sel     = ptr_q;
          sel_vld = 1'b1;
        end else if (req0_valid) begin
          sel     = 1'b0;
          sel_vld = 1'b1;
        end else if (req1_valid) begin
          sel     = 1'b1;
          sel_vld = 1'b1;
        end
      end
      LOCK0: begin
        sel     = 1'b0;
        sel_vld = 1'b1;
      end
      LOCK1: begin
        sel     = 1'b1;
        sel_vld = 1'b1;
      end
      default: begin
        sel     = ptr_q;
        sel_vld = 1'b0;
      end
    endcase

    req0_ready = sel_vld && !sel && load_en;
    req1_ready = sel_vld && sel && load_en;
    acc0       = req0_ready && req0_valid;
    acc1       = req1_ready && req1_valid;
    acc        = acc0 || acc1;
    acc_last   = acc1 ? req1_last : req0_last;
    acc_data   = acc1 ? req1_data : req0_data;
    own_vld    = sel ? req1_valid : req0_valid;

    data_d = data_q;
    vld_d  = vld_q;
    if (acc) begin
      data_d = acc_data;
      vld_d  = 1'b1;
    end else if (uart_data_in_ready) begin
      vld_d  = 1'b0;
    end

    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tevt_d  = 1'b0;
    if (acc) begin
      cnt_d = '0;
      if (acc_last) begin
        state_d = IDLE;
        ptr_d   = !sel;
      end else begin
        state_d = sel ? LOCK1 : LOCK0;
      end
    end else if (state_q != IDLE && !own_vld) begin
      // Only an absent owner ages the lock; back-pressure does not.
      if (cnt_q >= CNT_MAX) begin
        state_d = IDLE;
        ptr_d   = !sel;
        tevt_d  = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      tevt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      tevt_q  <= tevt_d;
    end
  end

  assign uart_data_in       = data_q;
  assign uart_data_in_valid = vld_q;
  assign grant              = {state_q == LOCK1, state_q == LOCK0};
  assign timeout_evt        = tevt_q;

endmodule
